// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-in/parallel-out deserializer. Collects qualified serial bits into a
// WIDTH-bit word and presents each completed word on a valid/ready handshake
// through an output holding register, so the next frame can shift in while the
// current word waits to be taken. A completed word that finds the holding
// register still occupied (and not being taken on that edge) is dropped and
// the sticky overrun flag is raised.
//
// Optional feature macro: SIPO_PARITY_EN
//   defined   : each frame is WIDTH data bits followed by one even-parity bit;
//               parity_err reports the parity result of the word on data_out.
//   undefined : frames are WIDTH bits, no parity state, parity_err tied to 0.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: first received bit lands in data_out[WIDTH-1]
//              0: first received bit lands in data_out[0]
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active low
//   d_in        in   serial data bit
//   bit_valid   in   qualifies d_in
//   data_ready  in   downstream accepts the word on data_out
//   data_out    out  assembled word, stable while data_valid=1
//   data_valid  out  data_out holds an unconsumed word
//   overrun     out  sticky: a completed word was dropped
//   parity_err  out  parity result for the word on data_out
//   bit_cnt     out  bits collected in the current frame
// -----------------------------------------------------------------------------
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           d_in,
  input  logic                           bit_valid,
  input  logic                           data_ready,
  output logic [WIDTH-1:0]               data_out,
  output logic                           data_valid,
  output logic                           overrun,
  output logic                           parity_err,
  output logic [$clog2(WIDTH+1)-1:0]     bit_cnt
);

  localparam int             CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_DATA = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             overrun_q;

  logic             take;        // holding register is emptied on this edge
  logic             frame_done;  // last bit of a frame is sampled on this edge
  logic [WIDTH-1:0] word_d;      // word delivered when frame_done

  // Shift direction decides where the first bit ends up after WIDTH shifts.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_d = {shift_q[WIDTH-2:0], d_in};
    end else begin : g_lsb_first
      assign shift_d = {d_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  assign take = data_valid_q & data_ready;

`ifdef SIPO_PARITY_EN
  typedef enum logic {
    S_COLLECT = 1'b0,
    S_PARITY  = 1'b1
  } state_e;

  state_e state_q;
  logic   parity_err_q;
  logic   perr_d;

  // In PARITY the data bits are already complete in shift_q; the incoming
  // bit is the parity bit and is folded into the even-parity check only.
  assign frame_done = bit_valid && (state_q == S_PARITY);
  assign word_d     = shift_q;
  assign perr_d     = (^shift_q) ^ d_in;
  assign parity_err = parity_err_q;
`else
  // The edge that samples data bit WIDTH completes the frame, so the word
  // is taken from the shift path rather than the register.
  assign frame_done = bit_valid && (bit_cnt_q == LAST_DATA);
  assign word_d     = shift_d;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
      state_q      <= S_COLLECT;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Output side: a transfer empties the holding register unless a new
      // word loads on the same edge (the load below takes priority).
      if (take) begin
        data_valid_q <= 1'b0;
      end
      if (frame_done) begin
        if (!data_valid_q || take) begin
          data_out_q   <= word_d;
          data_valid_q <= 1'b1;
`ifdef SIPO_PARITY_EN
          parity_err_q <= perr_d;
`endif
        end else begin
          overrun_q <= 1'b1;
        end
      end

      // Input side.
`ifdef SIPO_PARITY_EN
      case (state_q)
        S_COLLECT: begin
          if (bit_valid) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + CNT_ONE;
            if (bit_cnt_q == LAST_DATA) begin
              state_q <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (bit_valid) begin
            bit_cnt_q <= '0;
            state_q   <= S_COLLECT;
          end
        end
        default: begin
          state_q <= S_COLLECT;
        end
      endcase
`else
      if (bit_valid) begin
        shift_q   <= shift_d;
        bit_cnt_q <= frame_done ? '0 : (bit_cnt_q + CNT_ONE);
      end
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
//
// Drives two deserializers (MSB_FIRST=1 and MSB_FIRST=0) from the same serial
// stream and compares both against a frame-level reference model built from
// a queue of received bits. Directed scenarios first, then random traffic.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef SIPO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          d_in;
  logic          bit_valid;
  logic          data_ready;

  logic [W-1:0]  out_m, out_l;
  logic          dv_m, dv_l;
  logic          ovr_m, ovr_l;
  logic          perr_m, perr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .rst        (rst),
    .d_in       (d_in),
    .bit_valid  (bit_valid),
    .data_ready (data_ready),
    .data_out   (out_m),
    .data_valid (dv_m),
    .overrun    (ovr_m),
    .parity_err (perr_m),
    .bit_cnt    (cnt_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .rst        (rst),
    .d_in       (d_in),
    .bit_valid  (bit_valid),
    .data_ready (data_ready),
    .data_out   (out_l),
    .data_valid (dv_l),
    .overrun    (ovr_l),
    .parity_err (perr_l),
    .bit_cnt    (cnt_l)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: bits of the current frame, plus the holding register.
  bit           q_bits[$];
  logic         m_valid;
  logic         m_ovr;
  logic         m_perr;
  logic [W-1:0] m_out_m;
  logic [W-1:0] m_out_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Applies the frame-level rules for one clock edge using the inputs
  // presented before that edge.
  task automatic model_edge();
    logic         transfer;
    logic [W-1:0] wm, wl;
    logic         p;
    if (!rst) begin
      q_bits.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
      m_out_m = '0;
      m_out_l = '0;
      return;
    end
    transfer = m_valid && data_ready;
    if (transfer) m_valid = 1'b0;
    if (bit_valid) begin
      q_bits.push_back(d_in);
      if (q_bits.size() == FRAME) begin
        wm = '0;
        wl = '0;
        p  = 1'b0;
        for (int i = 0; i < W; i++) begin
          wm    = (wm << 1) | W'(q_bits[i]);
          wl[i] = q_bits[i];
        end
        for (int i = 0; i < FRAME; i++) p ^= q_bits[i];
        if (!m_valid) begin
          // Either the register was free or it is being taken this edge.
          m_valid = 1'b1;
          m_out_m = wm;
          m_out_l = wl;
`ifdef SIPO_PARITY_EN
          m_perr  = p;
`endif
        end else begin
          m_ovr = 1'b1;
        end
        q_bits.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".m.valid"}, 32'(dv_m),   32'(m_valid));
    chk({tag, ".l.valid"}, 32'(dv_l),   32'(m_valid));
    chk({tag, ".m.data"},  32'(out_m),  32'(m_out_m));
    chk({tag, ".l.data"},  32'(out_l),  32'(m_out_l));
    chk({tag, ".m.ovr"},   32'(ovr_m),  32'(m_ovr));
    chk({tag, ".l.ovr"},   32'(ovr_l),  32'(m_ovr));
    chk({tag, ".m.perr"},  32'(perr_m), 32'(m_perr));
    chk({tag, ".l.perr"},  32'(perr_l), 32'(m_perr));
    chk({tag, ".m.cnt"},   32'(cnt_m),  32'(q_bits.size()));
    chk({tag, ".l.cnt"},   32'(cnt_l),  32'(q_bits.size()));
  endtask

  // One clock: inputs set on the falling edge, model advanced on the rising
  // edge, DUT outputs compared 1 time unit later.
  task automatic step(input string tag, input logic r, input logic bv,
                      input logic d, input logic rdy);
    @(negedge clk);
    rst        = r;
    bit_valid  = bv;
    d_in       = d;
    data_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Sends one frame; the word is sent MSB first as a bit sequence, followed
  // by pbit when parity is built. rdy_last applies to the frame's final bit.
  task automatic send_frame(input string tag, input logic [W-1:0] w, input logic pbit,
                            input logic rdy_body, input logic rdy_last, input int gap);
    logic b;
    logic r;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) step(tag, 1'b1, 1'b0, 1'($urandom), rdy_body);
      end
      b = (i < W) ? w[W-1-i] : pbit;
      r = (i == FRAME - 1) ? rdy_last : rdy_body;
      step(tag, 1'b1, 1'b1, b, r);
    end
    $display("tb: frame %s word=0x%02h sent, data_out msb=0x%02h lsb=0x%02h valid=%0b ovr=%0b perr=%0b",
             tag, w, out_m, out_l, dv_m, ovr_m, perr_m);
  endtask

  initial begin
    rst        = 1'b0;
    d_in       = 1'b0;
    bit_valid  = 1'b0;
    data_ready = 1'b0;
    q_bits.delete();
    m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0; m_out_m = '0; m_out_l = '0;

    // Reset with random activity on the inputs.
    step("rst", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    step("rst", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_valid", 32'(dv_m),  32'd0);
    chk("rst_data",  32'(out_m), 32'd0);
    chk("rst_ovr",   32'(ovr_m), 32'd0);
    chk("rst_perr",  32'(perr_m), 32'd0);
    chk("rst_cnt",   32'(cnt_m), 32'd0);

    // Bit order: 1,1,0,0,1,0,1,0 with data_ready held high.
    send_frame("order", 8'hCA, 1'b0, 1'b1, 1'b1, 0);
    chk("order_valid", 32'(dv_m),  32'd1);
    chk("msb_word",    32'(out_m), 32'hCA);
    chk("lsb_word",    32'(out_l), 32'h53);
    chk("order_cnt",   32'(cnt_m), 32'd0);
    step("order_drain", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("order_one_cycle", 32'(dv_m), 32'd0);

    // Back-pressure and overrun.
    send_frame("bp1", 8'hCA, 1'b0, 1'b0, 1'b0, 0);
    chk("bp1_data", 32'(out_m), 32'hCA);
    send_frame("bp2", 8'h0F, 1'b0, 1'b0, 1'b0, 0);
    chk("ovr_hold_data", 32'(out_m), 32'hCA);
    chk("ovr_set",       32'(ovr_m), 32'd1);
    step("ovr_take", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ovr_valid_drop", 32'(dv_m),  32'd0);
    chk("ovr_sticky",     32'(ovr_m), 32'd1);

    // Transfer and completion on the same edge.
    step("rst2", 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame("sim1", 8'hCA, 1'b0, 1'b0, 1'b0, 0);
    send_frame("sim2", 8'h3C, 1'b0, 1'b0, 1'b1, 0);
    chk("sim_data",  32'(out_m), 32'h3C);
    chk("sim_valid", 32'(dv_m),  32'd1);
    chk("sim_ovr",   32'(ovr_m), 32'd0);
    step("sim_drain", 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame discards partial bits.
    for (int i = 0; i < 4; i++) step("partial", 1'b1, 1'b1, 1'($urandom), 1'b0);
    chk("partial_cnt", 32'(cnt_m), 32'd4);
    step("rst3", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst3_cnt", 32'(cnt_m), 32'd0);
    send_frame("a5", 8'hA5, 1'b0, 1'b1, 1'b1, 0);
    chk("a5_data", 32'(out_m), 32'hA5);
    chk("a5_valid", 32'(dv_m), 32'd1);
    step("a5_drain", 1'b1, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
    for (int gap = 0; gap <= 3; gap += 3) begin
      send_frame("par0", 8'hCA, 1'b0, 1'b0, 1'b0, gap);
      chk("par0_perr", 32'(perr_m), 32'd0);
      step("par0_drain", 1'b1, 1'b0, 1'b0, 1'b1);
      send_frame("par1", 8'hCA, 1'b1, 1'b0, 1'b0, gap);
      chk("par1_perr", 32'(perr_m), 32'd1);
      chk("par1_data", 32'(out_m),  32'hCA);
      step("par1_drain", 1'b1, 1'b0, 1'b0, 1'b1);
    end
`else
    // Idle gaps mid-frame are legal.
    send_frame("gap", 8'h96, 1'b0, 1'b0, 1'b0, 3);
    chk("gap_data", 32'(out_m), 32'h96);
    chk("gap_lsb",  32'(out_l), 32'h69);
    chk("gap_perr", 32'(perr_m), 32'd0);
    step("gap_drain", 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      step("rand", ($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in/parallel-out deserializer that consumes the registered serial bit stream produced by the team's D flip-flop stage (its `q` output) and assembles it into WIDTH-bit words. Each completed word is presented on a valid/ready output handshake. A dedicated output holding register lets the next word shift in while the current one waits. Overrun is flagged when a new word completes while the previous one has not been taken.

## Interface
- `WIDTH`, 8, word width in bits; legal range 2..32.
- `MSB_FIRST`, 1, bit order: 1 = first received bit lands in `data_out[WIDTH-1]`; 0 = first received bit lands in `data_out[0]`.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `d_in`  in  1  serial data bit (driven from the flip-flop stage's `q`).
- `bit_valid`  in  1  qualifies `d_in`; a bit is sampled only on edges where this is 1.
- `data_ready`  in  1  downstream accepts the word.
- `data_out`  out  WIDTH  assembled word; held stable while `data_valid`=1.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `overrun`  out  1  sticky; a completed word was dropped.
- `parity_err`  out  1  parity result for the word on `data_out` (see Configuration).
- `bit_cnt`  out  $clog2(WIDTH+1)  bits collected in the current frame.

## Operation
- States: COLLECT (shifting data bits) and PARITY (awaiting the parity bit; exists only with `SIPO_PARITY_EN`).
- COLLECT: on `bit_valid`=1, shift `d_in` into the shift register and increment `bit_cnt`.
- Word completion: the edge that samples data bit WIDTH completes the frame.
  - Without parity: the word completes on that edge and `bit_cnt` returns to 0.
  - With parity: the FSM moves to PARITY; the next valid bit is the parity bit, which completes the frame.
- Frame completion outcomes:
  - Holding register free (`data_valid`=0): load the word into `data_out` and set `data_valid`=1.
  - Holding register occupied and not being consumed this cycle: drop the new word, keep the old `data_out`, and set `overrun`=1.
- Handshake: the transfer occurs on any edge with `data_valid`=1 and `data_ready`=1. `data_valid` then clears, unless a frame completes on the same edge.
- Simultaneous transfer and completion: the new word loads, `data_valid` stays 1, and `overrun` is not set.
- `data_ready` is ignored while `data_valid`=0.
- `bit_valid`=0 holds all state; idle gaps mid-frame are legal.
- `overrun` clears only on reset.

## Timing
- Reset values, applied on the edge where `rst`=0: `data_out`=0, `data_valid`=0, `overrun`=0, `parity_err`=0, `bit_cnt`=0, FSM=COLLECT, shift register=0.
- Reset mid-frame discards the partial bits. The first valid bit after `rst` returns to 1 is bit 0 of a new frame.
- Latency: if the frame's final bit is sampled at edge N, `data_valid`=1 and `data_out` are visible after edge N.
- Minimum frame time is WIDTH cycles without parity, WIDTH+1 cycles with parity. Back-to-back frames are sustained at full rate with no bubbles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SIPO_PARITY_EN` defined:
  - Each frame is WIDTH data bits followed by 1 even-parity bit.
  - `parity_err` loads together with `data_out` and is 1 when the XOR of all WIDTH+1 bits is 1.
  - The word is delivered regardless of the parity result.
- `SIPO_PARITY_EN` undefined:
  - Frames are WIDTH bits and the PARITY state is not built.
  - `parity_err` is tied to 0.

## Test plan
- Reset: hold `rst`=0 for 2 cycles while driving random `d_in`/`bit_valid` -> all outputs 0, `bit_cnt`=0.
- MSB order: WIDTH=8, MSB_FIRST=1; bits 1,1,0,0,1,0,1,0 on consecutive edges with `data_ready`=1 -> `data_out`=0xCA, `data_valid` high for 1 cycle right after the 8th edge.
- LSB order: same bits with MSB_FIRST=0 -> `data_out`=0x53.
- Back-pressure and overrun:
  - Send 0xCA with `data_ready`=0, then 0x0F -> `data_out` stays 0xCA, `overrun`=1.
  - Raise `data_ready` -> `data_valid` drops; `overrun` stays 1.
- Simultaneous events:
  - Hold word 0xCA, then assert `data_ready` on the edge that completes the next word 0x3C -> `data_out`=0x3C, `data_valid` stays 1, `overrun`=0.
  - Separately, pull `rst` low after 4 bits, release, then send 0xA5 -> `data_out`=0xA5.
- Parity (`SIPO_PARITY_EN`):
  - 0xCA + parity 0 -> `parity_err`=0.
  - 0xCA + parity 1 -> `parity_err`=1, `data_out`=0xCA.
  - Gaps of 3 idle cycles between bits -> same results.
